// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera buffer unit.
//   cam_state_t   : camera control FSM states.
//   SEG_*         : active-low {g,f,e,d,c,b,a} glyphs for each state, plus blank.
//   SIG_*         : bit positions inside out_sig / peer_sig.
//   LEVEL_MAX     : highest buffer fill level (tenths of capacity).
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STANDBY  = 3'd1,
    FILM     = 3'd2,
    HOLD     = 3'd3,
    DOWNLOAD = 3'd4,
    FLUSH    = 3'd5
  } cam_state_t;

  localparam logic [6:0] SEG_IDLE     = 7'b0111111; // "-"
  localparam logic [6:0] SEG_STANDBY  = 7'b0010010; // "S"
  localparam logic [6:0] SEG_FILM     = 7'b0001110; // "F"
  localparam logic [6:0] SEG_HOLD     = 7'b0001001; // "H"
  localparam logic [6:0] SEG_DOWNLOAD = 7'b0100001; // "d"
  localparam logic [6:0] SEG_FLUSH    = 7'b1000110; // "C"
  localparam logic [6:0] SEG_BLANK    = 7'b1111111;

  localparam int SIG_STANDBY = 0;
  localparam int SIG_FILM    = 1;
  localparam int SIG_HALF    = 2;

  localparam logic [3:0] LEVEL_MAX = 4'd9;

endpackage

// File: rtl/cam_buffer_unit_seg7_digit.sv
// seg7_digit: combinational 4-bit to active-low 7-segment decoder.
//   digit : input value; 0..9 shown as decimal digits, 10..15 shown blank.
//   seg   : active-low segments {g,f,e,d,c,b,a}.
module seg7_digit
  import cam_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cam_buffer_unit.sv
// cam_buffer_unit: one camera of a two-camera recorder. Runs the camera
// control FSM, tracks the 0..9 buffer fill level and drives status outputs.
// Two instances are cross-connected (peer_sig of one = out_sig of the other).
//
// Build option: define CAM_SEG_DISPLAY_EN to build the 7-segment decoders;
// without it seg_state and seg_level are tied blank.
//
// Ports:
//   clock, reset       : clock; asynchronous active-high reset.
//   default_on         : reset state select, 1 = FILM, 0 = IDLE.
//   download           : level request to download the held buffer.
//   peer_sig[2:0]      : peer's out_sig {half, start-filming, standby request}.
//   out_sig[2:0]       : {FILM & level>=5, FILM & level==9, FILM & level>=8}.
//   level[3:0]         : fill level 0..9.
//   standby_n, film_n  : active-low state flags.
//   ready_to_download  : high in IDLE.
//   seg_state, seg_level : active-low segment patterns.
//
// Handshake: peer_sig and download are plain levels, sampled only on tick;
// there is no valid/ready pairing, the peer simply holds its request level.
module cam_buffer_unit
  import cam_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       default_on,
  input  logic       download,
  input  logic [2:0] peer_sig,
  output logic [2:0] out_sig,
  output logic [3:0] level,
  output logic       standby_n,
  output logic       film_n,
  output logic       ready_to_download,
  output logic [6:0] seg_state,
  output logic [6:0] seg_level
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  cam_state_t state, next_state;
  logic [3:0] next_level;
  logic       tick;

  // Tick generator: one-cycle pulse every STEP_CYCLES clocks.
  generate
    if (STEP_CYCLES > 1) begin : g_div
      logic [CW-1:0] tick_cnt;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          tick_cnt <= '0;
        else if (tick_cnt == CW'(STEP_CYCLES - 1))
          tick_cnt <= '0;
        else
          tick_cnt <= tick_cnt + 1'b1;
      end
      assign tick = (tick_cnt == CW'(STEP_CYCLES - 1));
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate

  // State register. Reset state depends on default_on so it is loaded
  // asynchronously along with the cleared level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= default_on ? FILM : IDLE;
      level <= 4'd0;
    end else begin
      state <= next_state;
      level <= next_level;
    end
  end

  // Next-state / next-level logic, active only on tick.
  always_comb begin
    next_state = state;
    next_level = level;
    if (tick) begin
      case (state)
        IDLE: begin
          if (peer_sig[SIG_FILM])         next_state = FILM;
          else if (peer_sig[SIG_STANDBY]) next_state = STANDBY;
        end
        STANDBY: begin
          if (peer_sig[SIG_FILM]) next_state = FILM;
        end
        FILM: begin
          if (level >= LEVEL_MAX) next_state = HOLD;
          else                    next_level = level + 4'd1;
        end
        HOLD: begin
          // Download takes priority over a flush triggered by the peer.
          if (download)                next_state = DOWNLOAD;
          else if (peer_sig[SIG_HALF]) next_state = FLUSH;
        end
        DOWNLOAD: begin
          // Continues to empty even if download is released.
          if (level == 4'd0) next_state = IDLE;
          else               next_level = level - 4'd1;
        end
        FLUSH: begin
          next_state = IDLE;
          next_level = 4'd0;
        end
        default: begin
          next_state = IDLE;
          next_level = 4'd0;
        end
      endcase
    end
  end

  // Outputs: purely combinational from state and level.
  always_comb begin
    out_sig                = 3'b000;
    out_sig[SIG_STANDBY]   = (state == FILM) && (level >= 4'd8);
    out_sig[SIG_FILM]      = (state == FILM) && (level == LEVEL_MAX);
    out_sig[SIG_HALF]      = (state == FILM) && (level >= 4'd5);
    standby_n              = (state != STANDBY);
    film_n                 = (state != FILM);
    ready_to_download      = (state == IDLE);
  end

`ifdef CAM_SEG_DISPLAY_EN
  always_comb begin
    seg_state = SEG_BLANK;
    case (state)
      IDLE:     seg_state = SEG_IDLE;
      STANDBY:  seg_state = SEG_STANDBY;
      FILM:     seg_state = SEG_FILM;
      HOLD:     seg_state = SEG_HOLD;
      DOWNLOAD: seg_state = SEG_DOWNLOAD;
      FLUSH:    seg_state = SEG_FLUSH;
      default:  seg_state = SEG_BLANK;
    endcase
  end

  seg7_digit u_seg_level (
    .digit (level),
    .seg   (seg_level)
  );
`else
  assign seg_state = SEG_BLANK;
  assign seg_level = SEG_BLANK;
`endif

endmodule

// File: tb/tb_cam_buffer_unit.sv
// Bench for cam_buffer_unit: directed scenarios on a STEP_CYCLES=1 instance
// and a STEP_CYCLES=4 instance sharing one clock.
module tb_cam_buffer_unit;

`ifdef CAM_SEG_DISPLAY_EN
  localparam logic [6:0] E_SEG_IDLE  = 7'b0111111;
  localparam logic [6:0] E_SEG_FILM  = 7'b0001110;
  localparam logic [6:0] E_SEG_HOLD  = 7'b0001001;
  localparam logic [6:0] E_SEG_DL    = 7'b0100001;
  localparam logic [6:0] E_SEG_FLUSH = 7'b1000110;
  localparam logic [6:0] E_DIG0      = 7'b1000000;
  localparam logic [6:0] E_DIG9      = 7'b0010000;
`else
  localparam logic [6:0] E_SEG_IDLE  = 7'b1111111;
  localparam logic [6:0] E_SEG_FILM  = 7'b1111111;
  localparam logic [6:0] E_SEG_HOLD  = 7'b1111111;
  localparam logic [6:0] E_SEG_DL    = 7'b1111111;
  localparam logic [6:0] E_SEG_FLUSH = 7'b1111111;
  localparam logic [6:0] E_DIG0      = 7'b1111111;
  localparam logic [6:0] E_DIG9      = 7'b1111111;
`endif

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, don1 = 1'b1, dl1 = 1'b0;
  logic [2:0] peer1 = 3'b000;
  logic [2:0] osig1;
  logic [3:0] lvl1;
  logic       sbn1, fn1, rdy1;
  logic [6:0] sst1, slv1;

  logic       rst4 = 1'b1, don4 = 1'b1, dl4 = 1'b0;
  logic [2:0] peer4 = 3'b000;
  logic [2:0] osig4;
  logic [3:0] lvl4;
  logic       sbn4, fn4, rdy4;
  logic [6:0] sst4, slv4;

  int tests_run = 0;
  int tests_failed = 0;

  cam_buffer_unit #(.STEP_CYCLES(1)) u_dut1 (
    .clock (clk), .reset (rst1), .default_on (don1), .download (dl1),
    .peer_sig (peer1), .out_sig (osig1), .level (lvl1), .standby_n (sbn1),
    .film_n (fn1), .ready_to_download (rdy1), .seg_state (sst1), .seg_level (slv1)
  );

  cam_buffer_unit #(.STEP_CYCLES(4)) u_dut4 (
    .clock (clk), .reset (rst4), .default_on (don4), .download (dl4),
    .peer_sig (peer4), .out_sig (osig4), .level (lvl4), .standby_n (sbn4),
    .film_n (fn4), .ready_to_download (rdy4), .seg_state (sst4), .seg_level (slv4)
  );

  // Driver tasks: advance n rising edges and settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset dut1 filming and run it to HOLD at level 9.
  task automatic go_hold();
    rst1 = 1'b1; don1 = 1'b1; peer1 = 3'b000; dl1 = 1'b0;
    #1;
    rst1 = 1'b0;
    step(10);
  endtask

  task automatic test_reset();
    rst1 = 1'b1; don1 = 1'b1; peer1 = 3'b000; dl1 = 1'b0;
    step(2);
    tests_run++;
    if (fn1 !== 1'b0) begin tests_failed++; $display("FAIL reset_film_n: got %b expected 0", fn1); end
    tests_run++;
    if (lvl1 !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", lvl1); end
    tests_run++;
    if ({sbn1, rdy1, osig1} !== 5'b10_000) begin tests_failed++;
      $display("FAIL reset_flags: got sbn=%b rdy=%b osig=%b expected 1 0 000", sbn1, rdy1, osig1); end
    tests_run++;
    if (sst1 !== E_SEG_FILM) begin tests_failed++; $display("FAIL reset_seg_state: got %b expected %b", sst1, E_SEG_FILM); end
    tests_run++;
    if (slv1 !== E_DIG0) begin tests_failed++; $display("FAIL reset_seg_level: got %b expected %b", slv1, E_DIG0); end
  endtask

  task automatic test_fill();
    rst1 = 1'b0;
    step(8);
    tests_run++;
    if (lvl1 !== 4'd8 || osig1 !== 3'b101) begin tests_failed++;
      $display("FAIL fill8: got level=%0d osig=%b expected 8 101", lvl1, osig1); end
    step(1);
    tests_run++;
    if (lvl1 !== 4'd9 || osig1 !== 3'b111 || fn1 !== 1'b0) begin tests_failed++;
      $display("FAIL fill9: got level=%0d osig=%b film_n=%b expected 9 111 0", lvl1, osig1, fn1); end
    tests_run++;
    if (slv1 !== E_DIG9) begin tests_failed++; $display("FAIL fill9_seg_level: got %b expected %b", slv1, E_DIG9); end
    step(1);
    tests_run++;
    if (lvl1 !== 4'd9 || osig1 !== 3'b000 || fn1 !== 1'b1 || rdy1 !== 1'b0) begin tests_failed++;
      $display("FAIL fill_hold: got level=%0d osig=%b film_n=%b rdy=%b expected 9 000 1 0", lvl1, osig1, fn1, rdy1); end
    tests_run++;
    if (sst1 !== E_SEG_HOLD) begin tests_failed++; $display("FAIL hold_seg_state: got %b expected %b", sst1, E_SEG_HOLD); end
    step(3);
    tests_run++;
    if (lvl1 !== 4'd9 || fn1 !== 1'b1 || rdy1 !== 1'b0) begin tests_failed++;
      $display("FAIL hold_stays: got level=%0d film_n=%b rdy=%b expected 9 1 0", lvl1, fn1, rdy1); end
  endtask

  task automatic test_download();
    dl1 = 1'b1;
    step(1);
    tests_run++;
    if (lvl1 !== 4'd9 || rdy1 !== 1'b0 || sst1 !== E_SEG_DL) begin tests_failed++;
      $display("FAIL dl_enter: got level=%0d rdy=%b seg=%b expected 9 0 %b", lvl1, rdy1, sst1, E_SEG_DL); end
    for (int i = 1; i <= 9; i++) begin
      if (i == 4) dl1 = 1'b0; // release mid-download; emptying continues
      step(1);
      tests_run++;
      if (lvl1 !== 4'(9 - i) || rdy1 !== 1'b0) begin tests_failed++;
        $display("FAIL dl_step%0d: got level=%0d rdy=%b expected %0d 0", i, lvl1, rdy1, 9 - i); end
    end
    step(1);
    tests_run++;
    if (rdy1 !== 1'b1 || lvl1 !== 4'd0 || sst1 !== E_SEG_IDLE) begin tests_failed++;
      $display("FAIL dl_idle: got rdy=%b level=%0d seg=%b expected 1 0 %b", rdy1, lvl1, sst1, E_SEG_IDLE); end
    // download outside HOLD is ignored
    dl1 = 1'b1;
    step(3);
    tests_run++;
    if (rdy1 !== 1'b1 || lvl1 !== 4'd0) begin tests_failed++;
      $display("FAIL dl_ignored_idle: got rdy=%b level=%0d expected 1 0", rdy1, lvl1); end
    dl1 = 1'b0;
  endtask

  task automatic test_flush();
    go_hold();
    peer1 = 3'b100;
    step(1);
    tests_run++;
    if (lvl1 !== 4'd9 || rdy1 !== 1'b0 || fn1 !== 1'b1 || sst1 !== E_SEG_FLUSH) begin tests_failed++;
      $display("FAIL flush_enter: got level=%0d rdy=%b film_n=%b seg=%b expected 9 0 1 %b", lvl1, rdy1, fn1, sst1, E_SEG_FLUSH); end
    step(1);
    tests_run++;
    if (rdy1 !== 1'b1 || lvl1 !== 4'd0) begin tests_failed++;
      $display("FAIL flush_idle: got rdy=%b level=%0d expected 1 0", rdy1, lvl1); end
    peer1 = 3'b000;
  endtask

  task automatic test_priority();
    go_hold();
    peer1 = 3'b100; dl1 = 1'b1;
    step(2);
    tests_run++;
    if (lvl1 !== 4'd8 || rdy1 !== 1'b0) begin tests_failed++;
      $display("FAIL dl_over_flush: got level=%0d rdy=%b expected 8 0", lvl1, rdy1); end
    peer1 = 3'b000; dl1 = 1'b0;
  endtask

  task automatic test_handshake();
    rst1 = 1'b1; don1 = 1'b0; peer1 = 3'b000; dl1 = 1'b0;
    #1;
    rst1 = 1'b0;
    tests_run++;
    if (rdy1 !== 1'b1 || fn1 !== 1'b1 || sbn1 !== 1'b1) begin tests_failed++;
      $display("FAIL hs_reset_idle: got rdy=%b film_n=%b sbn=%b expected 1 1 1", rdy1, fn1, sbn1); end
    peer1 = 3'b001;
    step(1);
    tests_run++;
    if (sbn1 !== 1'b0 || rdy1 !== 1'b0) begin tests_failed++;
      $display("FAIL hs_standby: got sbn=%b rdy=%b expected 0 0", sbn1, rdy1); end
    peer1 = 3'b000;
    step(2);
    tests_run++;
    if (sbn1 !== 1'b0) begin tests_failed++; $display("FAIL hs_standby_stay: got sbn=%b expected 0", sbn1); end
    peer1 = 3'b011;
    step(1);
    tests_run++;
    if (fn1 !== 1'b0 || sbn1 !== 1'b1 || lvl1 !== 4'd0) begin tests_failed++;
      $display("FAIL hs_standby_film: got film_n=%b sbn=%b level=%0d expected 0 1 0", fn1, sbn1, lvl1); end
    peer1 = 3'b000;
    rst1 = 1'b1;
    #1;
    rst1 = 1'b0;
    peer1 = 3'b010;
    step(1);
    tests_run++;
    if (fn1 !== 1'b0 || rdy1 !== 1'b0) begin tests_failed++;
      $display("FAIL hs_idle_film: got film_n=%b rdy=%b expected 0 0", fn1, rdy1); end
    rst1 = 1'b1;
    #1;
    rst1 = 1'b0;
    peer1 = 3'b011;
    step(1);
    tests_run++;
    if (fn1 !== 1'b0 || sbn1 !== 1'b1) begin tests_failed++;
      $display("FAIL hs_film_priority: got film_n=%b sbn=%b expected 0 1", fn1, sbn1); end
    peer1 = 3'b000;
  endtask

  task automatic test_async_reset();
    go_hold();
    dl1 = 1'b1;
    step(5);
    tests_run++;
    if (lvl1 !== 4'd5) begin tests_failed++; $display("FAIL ar_setup_level: got %0d expected 5", lvl1); end
    don1 = 1'b0;
    rst1 = 1'b1;
    #2; // still well before the next rising edge
    tests_run++;
    if (rdy1 !== 1'b1 || lvl1 !== 4'd0) begin tests_failed++;
      $display("FAIL ar_immediate: got rdy=%b level=%0d expected 1 0", rdy1, lvl1); end
    dl1 = 1'b0;
    step(1);
    rst1 = 1'b0;
  endtask

  task automatic test_step4();
    rst4 = 1'b1; don4 = 1'b1; peer4 = 3'b000; dl4 = 1'b0;
    step(1);
    rst4 = 1'b0;
    step(3);
    tests_run++;
    if (lvl4 !== 4'd0 || fn4 !== 1'b0) begin tests_failed++;
      $display("FAIL step4_3clk: got level=%0d film_n=%b expected 0 0", lvl4, fn4); end
    step(1);
    tests_run++;
    if (lvl4 !== 4'd1) begin tests_failed++; $display("FAIL step4_4clk: got %0d expected 1", lvl4); end
    step(3);
    tests_run++;
    if (lvl4 !== 4'd1) begin tests_failed++; $display("FAIL step4_7clk: got %0d expected 1", lvl4); end
    step(1);
    tests_run++;
    if (lvl4 !== 4'd2) begin tests_failed++; $display("FAIL step4_8clk: got %0d expected 2", lvl4); end
  endtask

  // Watchdog: the sequence is fixed-length; this only guards against a stall.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_download();
    test_flush();
    test_priority();
    test_handshake();
    test_async_reset();
    test_step4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cam_buffer_unit.md
Name: cam_buffer_unit

Overview:
- One camera of the two-camera space-station recorder: camera control FSM, 0–9 buffer fill level (tenths of capacity) and two active-low 7-segment display encodings.
- Two instances are cross-connected: each peer_sig input takes the other instance's out_sig.
- Hand-off: a filming camera warns its peer at 80%, hands over filming at 90%, then downloads on request or flushes once the peer reaches 50%.

Parameters:
- STEP_CYCLES, 1, clock cycles per fill/empty step (tick); range 1..2^16.

Ports:
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- default_on  in  1  state entered on reset: 1 = FILM, 0 = IDLE.
- download  in  1  level request to download the held buffer.
- peer_sig  in  3  peer out_sig: [0] standby request, [1] start-filming request, [2] peer at 50%.
- out_sig  out  3  [0] = FILM & level>=8; [1] = FILM & level==9; [2] = FILM & level>=5.
- level  out  4  fill level, 0..9.
- standby_n  out  1  low iff state == STANDBY.
- film_n  out  1  low iff state == FILM.
- ready_to_download  out  1  high iff state == IDLE.
- seg_state  out  7  active-low segments {g,f,e,d,c,b,a} for the current state.
- seg_level  out  7  active-low digit for level.

Behaviour:
- Reset (async, any time, including mid-download):
  - state = default_on ? FILM : IDLE; level = 0; tick counter = 0.
  - Outputs then follow the combinational rules.
- Tick: high for one cycle every STEP_CYCLES clocks; when STEP_CYCLES = 1 it is high every cycle. State and level update only on tick; peer_sig and download are sampled only on tick.
- States and their transitions (evaluated on tick):
  - IDLE: if peer_sig[1] -> FILM; else if peer_sig[0] -> STANDBY. peer_sig[1] has priority.
  - STANDBY: if peer_sig[1] -> FILM; otherwise stay.
  - FILM: if level == 9 -> HOLD with level held at 9; else level + 1.
  - HOLD: if download -> DOWNLOAD; else if peer_sig[2] -> FLUSH; otherwise stay. Download wins when both arrive on the same tick.
  - DOWNLOAD: if level == 0 -> IDLE; else level - 1. download may drop mid-download; emptying continues.
  - FLUSH: level = 0 and state -> IDLE in one tick.
- download outside HOLD is ignored.
- level never exceeds 9 and never wraps below 0.
- All outputs are combinational from state and level (zero latency).
- seg_state encodings:
  - IDLE "-" 0111111
  - STANDBY "S" 0010010
  - FILM "F" 0001110
  - HOLD "H" 0001001
  - DOWNLOAD "d" 0100001
  - FLUSH "C" 1000110
- seg_level: standard active-low digits:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Unused codes show blank, 1111111.

Optional Feature:
- CAM_SEG_DISPLAY_EN defined: seg_state and seg_level are driven as specified.
- Not defined: both outputs are tied to 1111111 (blank) and no decoders are built. All other outputs are unchanged.

Decomposition:
- Package cam_pkg holds:
  - state enum {IDLE, STANDBY, FILM, HOLD, DOWNLOAD, FLUSH};
  - the six segment constants plus SEG_BLANK;
  - out_sig bit indices SIG_STANDBY = 0, SIG_FILM = 1, SIG_HALF = 2;
  - LEVEL_MAX = 9.
- One sub-module: seg7_digit, a combinational 4-bit to active-low 7-segment decoder used for seg_level.

Test Plan:
- Reset, STEP_CYCLES = 1, default_on = 1, peer_sig = 0:
  - FILM, level 0, film_n = 0, seg_state = 0001110.
  - After 8 ticks: level 8, out_sig = 101.
  - After 9 ticks: out_sig = 111.
  - After 10 ticks: HOLD, level 9, out_sig = 000.
- From HOLD, download = 1: DOWNLOAD, level steps 9 -> 0 one per tick, then IDLE; ready_to_download = 1, seg_state = 0111111.
- From HOLD, peer_sig = 100, download = 0: FLUSH next tick, then IDLE with level 0.
- Same tick: peer_sig = 100 with download = 1 in HOLD -> DOWNLOAD (not FLUSH).
- Peer handshake from IDLE (default_on = 0):
  - peer_sig = 001 -> STANDBY, standby_n = 0;
  - then peer_sig = 011 -> FILM;
  - separately, peer_sig = 010 directly from IDLE -> FILM.
- Async reset mid-DOWNLOAD at level 5, default_on = 0: IDLE, level 0 immediately, without waiting for a clock edge. With STEP_CYCLES = 4, level advances only every 4th clock.
